// File: rtl/fir_top.sv
// fir_top: programmable 40-tap direct-form FIR filter with a host-written coefficient RAM
//   iClk12M          12 MHz system clock, rising-edge active
//   iRsn             asynchronous active-low reset
//   iEnSample600k    one-clock sample strobe
//   iCoeffUpdateFlag coefficient update mode: RAM writes enabled, output held
//   iCsnRam          RAM chip select, active low
//   iWrnRam          RAM write enable, active low
//   iAddrRam         RAM word address 0..63 (words >= TAPS are storage only)
//   iWrDtRam         signed coefficient write data
//   iNumOfCoeff      number of active taps, clamped to TAPS
//   iFirIn           signed input sample
//   oFirOut          signed saturated filter output
module fir_top #(
    parameter int TAPS   = 40,
    parameter int IN_W   = 3,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16
) (
    input  logic                     iClk12M,
    input  logic                     iRsn,
    input  logic                     iEnSample600k,
    input  logic                     iCoeffUpdateFlag,
    input  logic                     iCsnRam,
    input  logic                     iWrnRam,
    input  logic [5:0]               iAddrRam,
    input  logic signed [COEF_W-1:0] iWrDtRam,
    input  logic [5:0]               iNumOfCoeff,
    input  logic signed [IN_W-1:0]   iFirIn,
    output logic signed [OUT_W-1:0]  oFirOut
);
    localparam int P_W   = IN_W + COEF_W;
    // 6 guard bits cover up to 64 full-scale products
    localparam int ACC_W = P_W + 6;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [COEF_W-1:0] rRam [64];
    logic signed [IN_W-1:0]   rX [TAPS];
    logic                     rEnD;
    logic [5:0]               wNum;
    logic signed [P_W-1:0]    wProd;
    logic signed [ACC_W-1:0]  wSum;
    logic signed [OUT_W-1:0]  wSat;

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < 64; i++) rRam[i] <= '0;
        end else if (!iCsnRam && !iWrnRam && iCoeffUpdateFlag) begin
            rRam[iAddrRam] <= iWrDtRam;
        end
    end

    // The delay line keeps shifting during coefficient updates so history stays intact
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < TAPS; i++) rX[i] <= '0;
        end else if (iEnSample600k) begin
            rX[0] <= iFirIn;
            for (int i = 1; i < TAPS; i++) rX[i] <= rX[i-1];
        end
    end

    assign wNum = (iNumOfCoeff > 6'(TAPS)) ? 6'(TAPS) : iNumOfCoeff;

    always_comb begin
        wSum  = '0;
        wProd = '0;
        for (int k = 0; k < TAPS; k++) begin
            wProd = P_W'(rX[k]) * P_W'(rRam[k]);
            if (6'(k) < wNum) wSum = wSum + ACC_W'(wProd);
        end
    end

    assign wSat = (wSum > SAT_MAX) ? OUT_W'(SAT_MAX) :
                  (wSum < SAT_MIN) ? OUT_W'(SAT_MIN) : OUT_W'(wSum);

    // Output is computed one edge after the strobe, once the new sample sits in rX[0]
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            rEnD    <= 1'b0;
            oFirOut <= '0;
        end else begin
            rEnD <= iEnSample600k;
            if (rEnD && !iCoeffUpdateFlag) oFirOut <= wSat;
        end
    end
endmodule

// File: tb/tb_fir_top.sv
// tb_fir_top: randomized scoreboard bench for fir_top against a behavioural FIR model
module tb_fir_top;
    logic              iClk12M = 1'b0;
    logic              iRsn = 1'b0;
    logic              en = 1'b0;
    logic              flag = 1'b0;
    logic              csn = 1'b1;
    logic              wrn = 1'b1;
    logic [5:0]        addr = '0;
    logic [5:0]        num = 6'd40;
    logic signed [15:0] wdat = '0;
    logic signed [2:0]  fin = '0;
    logic signed [15:0] out;

    int nChecks = 0;
    int nErrors = 0;
    int cycle = 0;
    int coef [64];
    int hist [$];
    bit pend;
    int expOut;
    int expQ [$];

    always #5 iClk12M = ~iClk12M;

    fir_top dut (
        .iClk12M(iClk12M),
        .iRsn(iRsn),
        .iEnSample600k(en),
        .iCoeffUpdateFlag(flag),
        .iCsnRam(csn),
        .iWrnRam(wrn),
        .iAddrRam(addr),
        .iWrDtRam(wdat),
        .iNumOfCoeff(num),
        .iFirIn(fin),
        .oFirOut(out)
    );

    function automatic int firSum();
        int n = (num > 6'd40) ? 40 : int'(num);
        int s = 0;
        for (int k = 0; k < n; k++) s += hist[k] * coef[k];
        return (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
    endfunction

    function automatic void modelClear();
        foreach (coef[i]) coef[i] = 0;
        hist = {};
        repeat (40) hist.push_back(0);
        pend = 1'b0;
        expOut = 0;
    endfunction

    task automatic cyc();
        @(posedge iClk12M);
        cycle++;
        if (!iRsn) modelClear();
        else begin
            if (pend && !flag) expOut = firSum();
            if (!csn && !wrn && flag) coef[addr] = int'(wdat);
            if (en) begin
                hist.push_front(int'(fin));
                void'(hist.pop_back());
            end
            pend = en;
        end
        expQ.push_back(expOut);
        #1;
    endtask

    task automatic chk(input string name, input int exp);
        nChecks++;
        if (out !== 16'(exp)) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, out, exp, cycle);
        end
    endtask

    task automatic writeC(input int a, input int v);
        csn = 1'b0; wrn = 1'b0; addr = 6'(a); wdat = 16'(v);
        cyc();
        csn = 1'b1; wrn = 1'b1;
    endtask

    task automatic strobe(input int s);
        en = 1'b1; fin = 3'(s);
        cyc();
        en = 1'b0;
        repeat ($urandom_range(0, 1)) cyc();
    endtask

    task automatic strobeChk(input int s, input int exp, input string name);
        en = 1'b1; fin = 3'(s);
        cyc();
        en = 1'b0;
        cyc();
        chk(name, exp);
    endtask

    task automatic randInputs();
        en = 1'($urandom); flag = 1'($urandom); csn = 1'($urandom); wrn = 1'($urandom);
        addr = 6'($urandom); wdat = 16'($urandom); fin = 3'($urandom);
    endtask

    task automatic idleInputs();
        en = 1'b0; flag = 1'b0; csn = 1'b1; wrn = 1'b1;
    endtask

    task automatic midReset();
        @(negedge iClk12M);
        #1;
        iRsn = 1'b0;
        modelClear();
        #1;
        chk("async_reset", 0);
        randInputs();
        cyc();
        cyc();
        iRsn = 1'b1;
        idleInputs();
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(negedge iClk12M);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nChecks++;
                if (out !== 16'(e)) begin
                    nErrors++;
                    $display("FAIL scoreboard: got %0d, expected %0d (cycle %0d)", out, e, cycle);
                end
            end
        end
    end

    initial begin
        modelClear();
        randInputs();
        cyc();
        cyc();
        iRsn = 1'b1;
        idleInputs();
        num = 6'd40;
        chk("reset_out", 0);
        for (int i = 0; i < 10; i++) strobeChk(int'($urandom_range(0, 7)) - 4, 0, "zero_coef");

        flag = 1'b1; writeC(0, 1); flag = 1'b0;
        strobeChk(3, 3, "unit_tap_p3");
        strobeChk(-4, -4, "unit_tap_m4");

        flag = 1'b1;
        for (int k = 0; k < 40; k++) writeC(k, k + 1);
        flag = 1'b0;
        repeat (40) strobe(0);
        strobeChk(1, 1, "impulse_0");
        for (int k = 1; k < 40; k++) strobeChk(0, k + 1, "impulse_k");
        strobeChk(0, 0, "impulse_end");

        num = 6'd10;
        repeat (11) strobe(1);
        strobeChk(1, 55, "num10");
        num = 6'd0;
        strobeChk(1, 0, "num0");
        num = 6'd63;
        repeat (39) strobe(1);
        strobeChk(1, 820, "num63_clamp");
        num = 6'd40;
        strobeChk(1, 820, "num40");
        num = 6'd39;
        strobeChk(1, 780, "num39");
        num = 6'd40;

        flag = 1'b1;
        for (int k = 0; k < 40; k++) writeC(k, (k == 39) ? 32000 : 0);
        flag = 1'b0;
        repeat (40) strobe(3);
        strobeChk(3, 32767, "sat_pos");
        repeat (39) strobe(-4);
        strobeChk(-4, -32768, "sat_neg");

        flag = 1'b1;
        writeC(0, 5);
        writeC(39, 0);
        repeat (3) strobe(2);
        chk("frozen", -32768);
        flag = 1'b0;
        strobeChk(1, 5, "unfreeze_c0");

        flag = 1'b1;
        csn = 1'b1; wrn = 1'b0; addr = 6'd0; wdat = 16'sd100;
        cyc();
        csn = 1'b0; wrn = 1'b1;
        cyc();
        flag = 1'b0; csn = 1'b0; wrn = 1'b0; wdat = 16'sd200;
        cyc();
        csn = 1'b1; wrn = 1'b1;
        strobeChk(1, 5, "no_write");

        flag = 1'b1; csn = 1'b0; wrn = 1'b0; addr = 6'd0; wdat = 16'sd7; en = 1'b1; fin = 3'sd2;
        cyc();
        idleInputs();
        cyc();
        chk("same_edge", 14);

        midReset();
        strobeChk(3, 0, "after_reset");

        for (int i = 0; i < 1500; i++) begin
            flag = ($urandom_range(0, 3) == 0);
            csn = 1'($urandom); wrn = 1'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 39));
            wdat = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63) - 32);
            en = ($urandom_range(0, 2) == 0);
            fin = 3'($urandom);
            if ($urandom_range(0, 31) == 0) num = 6'($urandom);
            cyc();
            if (i == 750) midReset();
        end

        idleInputs();
        cyc();
        @(negedge iClk12M);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/fir_top.md
Name: fir_top

Overview:
- Programmable 40-tap direct-form FIR filter for a 600 kHz sample stream inside a 12 MHz clock domain.
- Holds coefficients in an internal 64×16 register-file RAM that the host writes through a chip-select/write-enable port.
- Filters a 3-bit signed input stream into a 16-bit signed saturated output, updated once per sample strobe.

Parameters:
- TAPS, 40, maximum number of filter taps / delay-line depth.
- IN_W, 3, input sample width (signed).
- COEF_W, 16, coefficient width (signed).
- OUT_W, 16, output width (signed).

Ports:
- iClk12M  in  1  12 MHz system clock; all state updates on the rising edge.
- iRsn  in  1  asynchronous active-low reset.
- iEnSample600k  in  1  one-clock sample strobe, nominally 1 in every 20 clocks.
- iCoeffUpdateFlag  in  1  1 = coefficient update mode; writes allowed, output held.
- iCsnRam  in  1  RAM chip select, active low.
- iWrnRam  in  1  RAM write enable, active low.
- iAddrRam  in  6  coefficient RAM word address, 0..63.
- iWrDtRam  in  16  signed coefficient write data.
- iNumOfCoeff  in  6  number of active taps.
- iFirIn  in  3  signed input sample, range -4..3.
- oFirOut  out  16  signed filtered output.

Behaviour:
- Reset (iRsn=0, asynchronous): all 64 RAM words = 0, all 40 delay-line entries = 0, internal strobe register = 0, oFirOut = 0.
- RAM write: on a rising edge with iCsnRam=0, iWrnRam=0 and iCoeffUpdateFlag=1, RAM[iAddrRam] <= iWrDtRam.
  - Any other combination: no write.
  - Writes are allowed on every clock, back-to-back.
- Coefficient k (tap k, 0..39) is RAM word k; words 40..63 are storage only.
- RAM read is combinational.
- A write is visible to the datapath from the following clock.
- Delay line: on a rising edge with iEnSample600k=1, x[0] <= iFirIn and x[k] <= x[k-1] for k = 1..39; x[39] is discarded.
  - The delay line shifts regardless of iCoeffUpdateFlag.
- Sum: S = Σ x[k]·c[k] over k < N, where N = min(iNumOfCoeff, 40); N = 0 gives S = 0.
  - Signed arithmetic throughout.
  - Each product is 19 bits; the accumulator is at least 25 bits, so there is no intermediate overflow.
- Output: the strobe is registered as enD.
  - On an edge with enD=1 and iCoeffUpdateFlag=0, oFirOut <= sat16(S).
  - Otherwise oFirOut holds.
  - sat16 clamps to the range -32768..32767.
- Latency: a sample captured at edge E appears in oFirOut at edge E+1.
- Output is constant between strobes.
- Strobe while iCoeffUpdateFlag=1: the sample is shifted in and the output holds. The first strobe after the flag drops outputs with the new coefficients and the full history.
- Strobe and write on the same edge: the delay-line shift and the RAM write both occur. The output computed on the next edge uses the new coefficient.
- iNumOfCoeff changes take effect on the next output update.
- Reset asserted mid-stream clears the history and output immediately.
- Strobe spacing is not required to be 20 clocks; strobes on consecutive clocks each shift and update.

Test Plan:
- Reset:
  - Stimulus: assert iRsn=0 for 2 clocks with random inputs.
  - Required: oFirOut = 0; with all coefficients 0 and iNumOfCoeff = 40, oFirOut stays 0 for 10 strobes.
- Unit tap:
  - Stimulus: write c0 = 1, others 0, iNumOfCoeff = 40, flag = 0; drive iFirIn = 3, then -4.
  - Required: oFirOut = 3, then -4, each one clock after its strobe.
- Impulse response:
  - Stimulus: write c[k] = k+1 for k = 0..39; apply one sample of 1, then 0.
  - Required: oFirOut = 1, 2, …, 40 on successive strobes, then 0.
- Tap count:
  - Stimulus: same coefficients as the impulse test, iNumOfCoeff = 10, iFirIn = 1 held.
  - Required: oFirOut settles at 55.
  - Stimulus: iNumOfCoeff = 0.
  - Required: oFirOut = 0.
- Saturation:
  - Stimulus: c39 = 0x7D00 (32000), others 0; iFirIn = 3 held for 40+ strobes.
  - Required: oFirOut = 32767.
  - Stimulus: iFirIn = -4.
  - Required: oFirOut = -32768.
- Update gating:
  - Stimulus: set flag = 1 and write c0 = 5 while strobes continue.
  - Required: oFirOut frozen.
  - Stimulus: drop the flag.
  - Required: the next strobe outputs a value using c0 = 5.
  - Stimulus: a write with iCsnRam = 1 or flag = 0.
  - Required: RAM unchanged.
